// File: rtl/sort_stream_ctrl.sv
// Sort chain controller: loads a packet into the chain, then
// drains it in sorted order onto a valid/ready output stream.
module sort_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LENGTH = 256,
  localparam int CNT_WIDTH = $clog2(MAX_LENGTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  ovf_o,
  output logic                  chain_clk_en_o,
  output logic                  chain_push_o,
  output logic [DATA_WIDTH-1:0] chain_data_o,
  input  logic [DATA_WIDTH-1:0] chain_data_i
);

  typedef enum logic {
    LOAD,
    UNLOAD
  } state_t;

  state_t state;
  state_t state_n;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] rem;
  logic [CNT_WIDTH-1:0] cnt_inc;

  logic accept;
  logic push;
  logic refill;
  logic done;

  assign cnt_inc = cnt + CNT_WIDTH'(push);

  // Next state plus the combinational chain and handshake controls.
  always_comb begin
    state_n        = state;
    s_ready_o      = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    refill         = 1'b0;
    done           = 1'b0;
    ovf_o          = 1'b0;
    chain_clk_en_o = 1'b0;
    chain_push_o   = 1'b0;
    chain_data_o   = '0;
    unique case (state)
      LOAD: begin
        s_ready_o      = !rst_i;
        accept         = s_valid_i & s_ready_o;
        push           = accept
                       & (cnt < CNT_WIDTH'(MAX_LENGTH));
        ovf_o          = accept & !push;
        chain_clk_en_o = push;
        chain_push_o   = push;
        if (push) chain_data_o = s_data_i;
        if (accept & s_last_i) state_n = UNLOAD;
      end
      UNLOAD: begin
        refill         = (!m_valid_o | m_ready_i)
                       & (rem != '0);
        done           = m_valid_o & m_ready_i & m_last_o;
        chain_clk_en_o = refill;
        if (done) state_n = LOAD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= LOAD;
    else       state <= state_n;
  end

  // Word counters and the output holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      rem       <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
    end else begin
      if (push) cnt <= cnt_inc;
      if (accept & s_last_i) rem <= cnt_inc;
      if (refill) begin
        m_data_o  <= chain_data_i;
        m_valid_o <= 1'b1;
        m_last_o  <= (rem == CNT_WIDTH'(1));
        rem       <= rem - CNT_WIDTH'(1);
      end else if (m_valid_o & m_ready_i) begin
        m_valid_o <= 1'b0;
      end
      if (done) begin
        m_last_o <= 1'b0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Scoreboard bench for sort_stream_ctrl with a behavioural
// sorted-queue chain model attached.
module tb_sort_stream_ctrl;

  localparam int DW = 16;
  localparam int ML = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          s_last_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          ovf_o;
  logic          chain_clk_en_o;
  logic          chain_push_o;
  logic [DW-1:0] chain_data_o;
  logic [DW-1:0] chain_data_i;

  sort_stream_ctrl #(
    .DATA_WIDTH(DW),
    .MAX_LENGTH(ML)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .s_data_i      (s_data_i),
    .s_last_i      (s_last_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .ovf_o         (ovf_o),
    .chain_clk_en_o(chain_clk_en_o),
    .chain_push_o  (chain_push_o),
    .chain_data_o  (chain_data_o),
    .chain_data_i  (chain_data_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int mode = 0;

  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic          exp_ovf[$];
  logic [DW-1:0] pkt_q[$];

  bit            first_pkt = 1'b1;
  bit            prev_stall = 1'b0;
  bit            chk_rdy = 1'b0;
  logic [DW-1:0] pd;
  logic          pl;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Chain model: ascending sorted queue, head is the smallest.
  logic [DW-1:0] chain_q[$];
  always @(posedge clk_i or posedge rst_i) begin
    int k;
    if (rst_i) begin
      chain_q.delete();
      chain_data_i <= '1;
    end else begin
      if (chain_clk_en_o) begin
        if (chain_push_o) begin
          k = 0;
          while (k < chain_q.size()
                 && chain_q[k] <= chain_data_o) k++;
          chain_q.insert(k, chain_data_o);
        end else if (chain_q.size() > 0) begin
          void'(chain_q.pop_front());
        end
      end
      chain_data_i <= (chain_q.size() > 0) ? chain_q[0] : '1;
    end
  end

  // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random,
  // 3 left to the directed code.
  initial begin
    int t;
    t = 0;
    m_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      case (mode)
        0: m_ready_i = 1'b1;
        1: begin
          m_ready_i = (t % 4 == 0) || (t % 4 == 3);
          t++;
        end
        2: m_ready_i = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  // Monitor: compares outputs and input-side pulses.
  initial begin
    logic [DW-1:0] d;
    logic          l;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        prev_stall = 1'b0;
        chk_rdy    = 1'b0;
      end else begin
        if (chk_rdy) begin
          chk("ready_after_last", s_ready_o, 1);
          chk_rdy = 1'b0;
        end
        if (s_valid_i && s_ready_o) begin
          if (exp_ovf.size() == 0) begin
            chk("unexpected_accept", 1, 0);
          end else begin
            l = exp_ovf.pop_front();
            chk("ovf", ovf_o, l);
            chk("push_en", chain_clk_en_o, !l);
          end
        end
        if (prev_stall) begin
          chk("hold_valid", m_valid_o, 1);
          chk("hold_data", m_data_o, pd);
          chk("hold_last", m_last_o, pl);
        end
        if (m_valid_o && first_pkt) begin
          chk("latency", cyc - hs_cyc, 2);
          first_pkt = 1'b0;
        end
        if (m_valid_o && !m_ready_i) begin
          chk("stall_no_pop", chain_clk_en_o, 0);
          prev_stall = 1'b1;
          pd = m_data_o;
          pl = m_last_o;
        end else begin
          prev_stall = 1'b0;
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_data.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            d = exp_data.pop_front();
            l = exp_last.pop_front();
            chk("out_data", m_data_o, d);
            chk("out_last", m_last_o, l);
            if (l) begin
              first_pkt = 1'b1;
              chk_rdy   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Sends pkt_q; the reference result is the first ML accepted
  // words sorted ascending.
  task automatic send_pkt(input bit gaps);
    logic [DW-1:0] acc[$];
    int n;
    int budget;
    acc = {};
    n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      s_valid_i = 1'b1;
      s_data_i  = pkt_q[i];
      s_last_i  = (i == n - 1);
      budget = 0;
      while (!s_ready_o && budget < 400) begin
        @(negedge clk_i);
        budget++;
      end
      if (!s_ready_o) begin
        chk("in_timeout", 0, 1);
        s_valid_i = 1'b0;
        return;
      end
      if (i == 0) chk("accept_after_drain", exp_data.size(), 0);
      exp_ovf.push_back(acc.size() >= ML);
      if (acc.size() < ML) acc.push_back(pkt_q[i]);
      if (i == n - 1) begin
        hs_cyc = cyc;
        acc.sort();
        for (int j = 0; j < acc.size(); j++) begin
          exp_data.push_back(acc[j]);
          exp_last.push_back(j == acc.size() - 1);
        end
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk_i);
        s_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_data.size() != 0 || m_valid_o) && budget < 500) begin
      @(negedge clk_i);
      budget++;
    end
    if (budget >= 500) chk("drain_timeout", 0, 1);
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    int budget;
    rst_i     = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 16'h1234;
    s_last_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_clk_en", chain_clk_en_o, 0);
    chk("rst_push", chain_push_o, 0);
    chk("rst_chain_data", chain_data_o, 0);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", s_ready_o, 1);

    mode = 0;
    pkt_q = '{16'd5, 16'd3, 16'd9, 16'd1};
    send_pkt(0);
    drain();

    pkt_q = '{16'h00AA};
    send_pkt(0);
    drain();

    mode = 1;
    pkt_q = '{16'd40, 16'd11, 16'd27, 16'd3};
    send_pkt(0);
    drain();

    mode = 0;
    pkt_q = '{16'd7, 16'd2, 16'd8, 16'd6, 16'd1, 16'd0};
    send_pkt(0);
    drain();

    pkt_q = '{16'd4, 16'd4, 16'd2};
    send_pkt(0);
    pkt_q = '{16'hFFFE, 16'd0};
    send_pkt(0);
    drain();

    mode = 2;
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 6);
      pkt_q = {};
      for (int i = 0; i < n; i++) begin
        if (p % 2 == 0) pkt_q.push_back(DW'($urandom_range(0, 7)));
        else            pkt_q.push_back(DW'($urandom));
      end
      send_pkt(1);
    end
    drain();

    mode = 3;
    m_ready_i = 1'b0;
    pkt_q = '{16'd9, 16'd5, 16'd7};
    send_pkt(0);
    budget = 0;
    while (!m_valid_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    chk("rst_test_valid", m_valid_o, 1);
    @(negedge clk_i);
    m_ready_i = 1'b1;
    @(negedge clk_i);
    m_ready_i = 1'b0;
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid_o, 0);
    chk("midrst_m_data", m_data_o, 0);
    chk("midrst_m_last", m_last_o, 0);
    chk("midrst_s_ready", s_ready_o, 0);
    chk("midrst_clk_en", chain_clk_en_o, 0);
    exp_data.delete();
    exp_last.delete();
    exp_ovf.delete();
    first_pkt  = 1'b1;
    prev_stall = 1'b0;
    chk_rdy    = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    mode  = 0;
    pkt_q = '{16'd3, 16'd1};
    send_pkt(0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Control stage that sits directly upstream and downstream of the sequential sort chain.
- Accepts an input packet of up to MAX_LENGTH words on a valid/ready stream with a last marker, and pushes each word into the chain.
- After the last word, pops the chain once per stored word and emits the words in sorted order as an output valid/ready stream with a last marker.
- Drives the chain's clock-enable and push/pop controls; the chain itself holds all packet data.

Parameters:
- DATA_WIDTH, 16, word width; must match the attached chain.
- MAX_LENGTH, 256, packet capacity in words; must match the attached chain.
- CNT_WIDTH, $clog2(MAX_LENGTH+1), width of the word counter (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_valid_i  in  1  input word valid
- s_ready_o  out  1  input word accepted when high with s_valid_i
- s_data_i  in  DATA_WIDTH  input word
- s_last_i  in  1  marks the final word of the packet
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream accepts the output word
- m_data_o  out  DATA_WIDTH  sorted output word
- m_last_o  out  1  marks the final sorted word
- ovf_o  out  1  one-cycle pulse for each input word dropped due to overflow
- chain_clk_en_o  out  1  chain step enable
- chain_push_o  out  1  1 = insert chain_data_o, 0 = pop the head
- chain_data_o  out  DATA_WIDTH  word to insert
- chain_data_i  in  DATA_WIDTH  current chain head (smallest or largest word, per the chain's direction)

Behaviour:
- Chain contract:
  - A push or pop takes effect at the clock edge where chain_clk_en_o=1.
  - chain_data_i reflects the new head from the next cycle.
  - chain_clk_en_o=0 holds the chain unchanged.
  - Popping N times after N pushes returns the chain to its sentinel (empty) state.
- Reset (async): state=LOAD, cnt=0, s_ready_o=0 during reset then 1.
  - m_valid_o=0, m_last_o=0, m_data_o=0, ovf_o=0.
  - chain_clk_en_o=0, chain_push_o=0, chain_data_o=0.
- chain_clk_en_o, chain_push_o, chain_data_o and ovf_o are combinational from state and handshakes. No registered delay is allowed, so each push/pop aligns with its handshake edge.
- State LOAD:
  - s_ready_o=1.
  - On s_valid_i & s_ready_o:
    - If cnt<MAX_LENGTH: chain_clk_en_o=1, chain_push_o=1, chain_data_o=s_data_i, cnt<=cnt+1.
    - Otherwise: no chain step, word dropped, ovf_o=1 for that cycle.
  - If s_last_i is also high: go to UNLOAD next cycle, with rem<=updated cnt.
  - m_valid_o=0 throughout LOAD.
- State UNLOAD:
  - s_ready_o=0.
  - Output register refill condition: (!m_valid_o | m_ready_i) & rem!=0. When it holds:
    - chain_clk_en_o=1, chain_push_o=0.
    - m_data_o<=chain_data_i, m_valid_o<=1, m_last_o<=(rem==1), rem<=rem-1.
  - If m_ready_i & m_valid_o and no refill: m_valid_o<=0.
  - When m_valid_o & m_ready_i & m_last_o: m_valid_o<=0, m_last_o<=0, cnt<=0, state<=LOAD. The chain is already empty at this point.
  - Sustained throughput with m_ready_i held high: one word per cycle. The first m_valid_o arrives one cycle after entering UNLOAD.
- Latency: last input handshake at cycle T gives first output valid at T+2.
- Backpressure: m_data_o and m_last_o are held stable while m_valid_o & !m_ready_i; no chain pop occurs then.
- Overflow: a packet longer than MAX_LENGTH outputs its first MAX_LENGTH words, sorted. If the dropped word carries s_last_i, the transition to UNLOAD still happens.
- Single-word packet (first word has s_last_i): rem=1, and exactly one output word is produced with m_last_o=1.
- Reset mid-operation (LOAD or UNLOAD): all state clears immediately. The chain shares rst_i and clears as well; no partial output follows.

Test Plan:
- Push 5,3,9,1 (last on 1) with m_ready_i=1 → outputs 1,3,5,9 on consecutive cycles, m_last_o only with 9, first m_valid_o two cycles after the last input handshake.
- Single word 0x00AA with last → one output 0x00AA with m_last_o=1, then s_ready_o=1 on the following cycle.
- 4-word packet, m_ready_i toggling 1,0,0,1,… → m_data_o stable while stalled, chain_clk_en_o=0 on stall cycles, sorted order preserved.
- MAX_LENGTH=4, send 7,2,8,6,1,0 (last on 0) → ovf_o pulses on 1 and 0, output is 2,6,7,8 with last on 8.
- Two back-to-back packets {4,4,2} then {0xFFFE,0} → outputs 2,4,4 then 0,0xFFFE; duplicates preserved; second packet is not accepted until the first one's last beat.
- Assert rst_i while the second of three output words is pending → all outputs go to 0 immediately; after release, packet {3,1} outputs 1,3.
